// File: rtl/mac_frame_accumulator.sv
// rtl/mac_frame_accumulator.sv - frame summing consumer of DSP MAC results; optional clamp via MAC_ACC_SATURATE_EN
module mac_frame_accumulator #(
    parameter int P_WIDTH     = 17,
    parameter int ACC_WIDTH   = 20,
    parameter int FRAME_LEN   = 16,
    parameter int DSP_LATENCY = 3,
    parameter int CNT_WIDTH   = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic                 op_last,
    input  logic [P_WIDTH-1:0]   p_in,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic [CNT_WIDTH-1:0] res_count,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DSP_LATENCY-1:0] vdly;
    logic [DSP_LATENCY-1:0] ldly;
    logic                   s_valid;
    logic                   s_last;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   p_ext;
    logic [ACC_WIDTH-1:0]   add_res;
    logic [ACC_WIDTH-1:0]   sum_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic                   close;

    // The strobe that left with the operands arrives here together with P.
    assign s_valid = vdly[DSP_LATENCY-1];
    assign s_last  = ldly[DSP_LATENCY-1];
    assign p_ext   = ACC_WIDTH'(p_in);

    // Operand-launch strobe delay line; clearing it on reset kills in-flight results
    always_ff @(posedge clk) begin
        if (rst) begin
            vdly <= '0;
            ldly <= '0;
        end else begin
            vdly[0] <= op_valid;
            ldly[0] <= op_valid & op_last;
            for (int i = 1; i < DSP_LATENCY; i++) begin
                vdly[i] <= vdly[i-1];
                ldly[i] <= ldly[i-1];
            end
        end
    end

`ifdef MAC_ACC_SATURATE_EN
    logic [ACC_WIDTH:0] wide_sum;

    // Once the carry appears the sum pins at all-ones; further adds keep it there.
    assign wide_sum = {1'b0, acc} + {1'b0, p_ext};
    assign add_res  = wide_sum[ACC_WIDTH] ? '1 : wide_sum[ACC_WIDTH-1:0];
`else
    assign add_res  = acc + p_ext;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, running sum/count including the current sample, and frame close detect
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        sum_nxt   = '0;
        close     = 1'b0;
        if (state == IDLE) begin
            cnt_nxt = CNT_WIDTH'(1);
            sum_nxt = p_ext;
        end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
            sum_nxt = add_res;
        end
        close = s_valid && (s_last || (cnt_nxt == CNT_WIDTH'(FRAME_LEN)));
        if (state == IDLE) begin
            if (s_valid && !close) begin
                state_nxt = ACCUM;
            end
        end else begin
            if (close) begin
                state_nxt = IDLE;
            end
        end
    end

    assign busy = (state == ACCUM);

    // Accumulator and sample counter; cleared on close so the next frame starts clean
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (s_valid) begin
            if (close) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_nxt;
                cnt <= cnt_nxt;
            end
        end
    end

    // Result register: load on close when free or being accepted, otherwise drop and flag overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data  <= '0;
            res_count <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (close) begin
                if (!res_valid || res_ready) begin
                    res_data  <= sum_nxt;
                    res_count <= cnt_nxt;
                    res_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// tb/tb_mac_frame_accumulator.sv - self-checking bench for mac_frame_accumulator
module tb_mac_frame_accumulator;

    localparam int P_W = 17;
    localparam int A_W = 20;
    localparam int LAT = 3;
    localparam int C_W = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           op_valid = 1'b0;
    logic           op_last = 1'b0;
    logic [P_W-1:0] op_p = '0;
    logic [P_W-1:0] p_in;
    logic [A_W-1:0] res_data;
    logic [C_W-1:0] res_count;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic           busy;
    logic           overrun;

    int tests = 0;
    int fails = 0;

    mac_frame_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .p_in      (p_in),
        .res_data  (res_data),
        .res_count (res_count),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // DSP model: P presented LAT cycles after its operands are launched
    logic [P_W-1:0] ppipe [0:LAT-1];
    always @(posedge clk) begin
        ppipe[0] <= op_p;
        for (int i = 1; i < LAT; i++) ppipe[i] <= ppipe[i-1];
    end
    assign p_in = ppipe[LAT-1];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_data"}, int'(res_data), 0);
        check({tag, "_res_count"}, int'(res_count), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    task automatic send_frame(input int len, input int base, input int step, input int gap, input bit use_last);
        for (int i = 0; i < len; i++) begin
            op_valid = 1'b1;
            op_last  = use_last && (i == len - 1);
            op_p     = P_W'(base + i * step);
            @(negedge clk);
            op_valid = 1'b0;
            op_last  = 1'b0;
            op_p     = '0;
            if (i != len - 1) repeat (gap) @(negedge clk);
        end
    endtask

    // Called on the first negedge after the closing launch
    task automatic collect(input string name, input int exp_d, input int exp_c);
        int w;
        w = 1;
        while (!res_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({name, "_latency"}, w, LAT + 1);
        check({name, "_data"}, int'(res_data), exp_d);
        check({name, "_count"}, int'(res_count), exp_c);
        @(negedge clk);
        check({name, "_hold"}, int'(res_data), exp_d);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_drop"}, int'(res_valid), 0);
    endtask

    typedef struct {
        int len;
        int base;
        int step;
        int gap;
        bit use_last;
        int exp_d;
        int exp_c;
    } vec_t;

    vec_t vecs [5];

    int got_d [$];
    int got_c [$];
    int got_t [$];

    initial begin
        int sat_exp;
`ifdef MAC_ACC_SATURATE_EN
        sat_exp = 1048575;
`else
        sat_exp = 1048560;
`endif
        vecs[0] = '{4, 10, 10, 0, 1'b1, 100, 4};
        vecs[1] = '{16, 1000, 0, 0, 1'b0, 16000, 16};
        vecs[2] = '{16, 131071, 0, 0, 1'b0, sat_exp, 16};
        vecs[3] = '{1, 7, 0, 0, 1'b1, 7, 1};
        vecs[4] = '{5, 100, 1, 2, 1'b1, 510, 5};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].len, vecs[i].base, vecs[i].step, vecs[i].gap, vecs[i].use_last);
            collect($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_c);
            check($sformatf("vec%0d_overrun", i), int'(overrun), 0);
        end

        // Reset with two samples summed and three still in flight
        send_frame(5, 1, 0, 0, 1'b0);
        check("midreset_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(2, 6, -2, 0, 1'b1);
        collect("after_reset", 10, 2);

        // Back-to-back two-sample frames with the consumer always ready
        res_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                op_valid = 1'b1;
                op_last  = (c % 2) == 1;
                op_p     = P_W'(c + 1);
            end else begin
                op_valid = 1'b0;
                op_last  = 1'b0;
                op_p     = '0;
            end
            @(negedge clk);
            if (res_valid) begin
                got_d.push_back(int'(res_data));
                got_c.push_back(int'(res_count));
                got_t.push_back(c);
            end
        end
        res_ready = 1'b0;
        check("b2b_results", got_d.size(), 4);
        for (int k = 0; k < got_d.size() && k < 4; k++) begin
            check($sformatf("b2b%0d_data", k), got_d[k], 4 * k + 3);
            check($sformatf("b2b%0d_count", k), got_c[k], 2);
            check($sformatf("b2b%0d_cycle", k), got_t[k], 4 + 2 * k);
        end
        check("b2b_overrun", int'(overrun), 0);

        // Second frame closes while the first result is still held
        send_frame(1, 5, 0, 0, 1'b1);
        send_frame(2, 3, 1, 0, 1'b1);
        repeat (6) @(negedge clk);
        check("ovr_valid", int'(res_valid), 1);
        check("ovr_data", int'(res_data), 5);
        check("ovr_count", int'(res_count), 1);
        check("ovr_flag", int'(overrun), 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("ovr_accept_drop", int'(res_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        rst = 1'b1;
        @(negedge clk);
        check("ovr_cleared", int'(overrun), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
